// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the 32-bit MIPS ALU.
//   ALU_W        data width (32)
//   ALU_*        4-bit ALU control codes decoded by alu
//   alu_is_sub   1 for ops that drive the shared adder in subtract mode
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // SUB, SLT and SLTU all read their answer off A - B.
  function automatic logic alu_is_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared 33-bit adder/subtractor for ADD, SUB, SLT and SLTU.
//   a, b   operands
//   sub    0: a + b, 1: a + ~b + 1
//   sum    low 32 bits of the result
//   carry  bit 32 of the sum (for subtract: 1 = no borrow, i.e. a >= b unsigned)
//   ovf    signed overflow of the add/subtract
//   lt     signed a < b (valid when sub = 1), immune to overflow
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             lt
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   full;

  assign b_eff = sub ? ~b : b;
  // The +1 of two's-complement negation rides in as the carry-in.
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
  assign sum   = full[ALU_W-1:0];
  assign carry = full[ALU_W];

  // Operand signs agree (after inverting b) but the result sign flipped.
  assign ovf   = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);

  // The raw sign is wrong exactly when the subtract overflowed.
  assign lt    = sum[ALU_W-1] ^ ovf;

endmodule

// File: rtl/alu.sv
// alu: combinational 32-bit MIPS ALU with an optional registered flag pair.
//   clk, reset  clock and synchronous active-high reset (flag register only)
//   A, B        operands
//   op          4-bit ALU control code (see alu_pkg)
//   RES         result, combinational; unknown op codes give 0
//   ZERO        RES == 0, combinational
//   OVF_Q       registered signed overflow of ADD/SUB, else 0
//   CARRY_Q     registered carry-out of ADD/SUB, else 0
// Build option: define ALU_STATUS_FLAGS_EN to compile in the flag register.
// Without it OVF_Q/CARRY_Q are constant 0 and clk/reset go unused.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [3:0]       op,
  output logic [ALU_W-1:0] RES,
  output logic             ZERO,
  output logic             OVF_Q,
  output logic             CARRY_Q
);

  logic [ALU_W-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;
  logic             as_lt;

  alu_addsub u_addsub (
    .a     (A),
    .b     (B),
    .sub   (alu_is_sub(op)),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf),
    .lt    (as_lt)
  );

  always_comb begin
    RES = '0;
    case (op)
      ALU_AND:  RES = A & B;
      ALU_OR:   RES = A | B;
      ALU_ADD:  RES = as_sum;
      ALU_SUB:  RES = as_sum;
      ALU_SLT:  RES = {{(ALU_W-1){1'b0}}, as_lt};
      // Unsigned less-than is the borrow, i.e. no carry out of A - B.
      ALU_SLTU: RES = {{(ALU_W-1){1'b0}}, ~as_carry};
      ALU_NOR:  RES = ~(A | B);
      ALU_XOR:  RES = A ^ B;
      default:  RES = '0;
    endcase
  end

  assign ZERO = (RES == '0);

`ifdef ALU_STATUS_FLAGS_EN
  logic flag_op;

  assign flag_op = (op == ALU_ADD) || (op == ALU_SUB);

  always_ff @(posedge clk) begin
    if (reset) begin
      OVF_Q   <= 1'b0;
      CARRY_Q <= 1'b0;
    end else begin
      OVF_Q   <= flag_op & as_ovf;
      CARRY_Q <= flag_op & as_carry;
    end
  end
`else
  assign OVF_Q   = 1'b0;
  assign CARRY_Q = 1'b0;

  // Ports and adder outputs kept for interface compatibility only.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, as_ovf};
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed cases first, then random
// operands/op codes compared against a plain-arithmetic reference model.
// Flag expectations follow ALU_STATUS_FLAGS_EN (all-zero when undefined).
module tb_alu;

`ifdef ALU_STATUS_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  op;
  logic [31:0] RES;
  logic        ZERO, OVF_Q, CARRY_Q;

  int total = 0;
  int bad   = 0;

  alu dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .op      (op),
    .RES     (RES),
    .ZERO    (ZERO),
    .OVF_Q   (OVF_Q),
    .CARRY_Q (CARRY_Q)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] o);
    case (o)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return a ^ b;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Flags from wide signed/unsigned arithmetic rather than bit tricks.
  task automatic ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                           output logic ovf, output logic cy);
    longint s;
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    cy  = 1'b0;
    if (o == 4'b0010) begin
      s   = sa + sb;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      cy  = (longint'(a) + longint'(b)) > 64'sd4294967295;
    end else if (o == 4'b0110) begin
      s   = sa - sb;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      cy  = (a >= b);
    end
  endtask

  // ---------------- checkers ----------------
  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Apply just after a posedge, check RES/ZERO 60 ns later, then the flags
  // just after the next posedge (which sampled these same inputs).
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] o, input logic rst);
    logic [31:0] er;
    logic        eo, ec;
    A = a; B = b; op = o; reset = rst;
    er = ref_res(a, b, o);
    ref_flags(a, b, o, eo, ec);
    if (rst || !FLAGS) begin
      eo = 1'b0;
      ec = 1'b0;
    end
    #60;
    chk32({tag, ".res"}, RES, er);
    chk1({tag, ".zero"}, ZERO, (er == 32'd0));
    @(posedge clk);
    #1;
    chk1({tag, ".ovf"}, OVF_Q, eo);
    chk1({tag, ".carry"}, CARRY_Q, ec);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [6];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'hFFFF_FFFF;
    edges[5] = 32'h8000_0001;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    A = '0; B = '0; op = 4'b0000; reset = 1'b1;

    // Reset state of the flag register.
    @(posedge clk);
    #1;
    chk1("reset.ovf", OVF_Q, 1'b0);
    chk1("reset.carry", CARRY_Q, 1'b0);

    // Directed cases.
    step("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
    step("add_cy",   32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
    step("sub_eq",   32'h1234_5678, 32'h1234_5678, 4'b0110, 1'b0);
    step("sub_ovf",  32'h8000_0000, 32'h0000_0001, 4'b0110, 1'b0);
    step("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 1'b0);
    step("sltu_neg", 32'hFFFF_FFFF, 32'h0000_0001, 4'b1111, 1'b0);
    step("slt_ovf",  32'h8000_0000, 32'h0000_0001, 4'b0111, 1'b0);
    step("slt_ovf2", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b0);
    step("and",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 1'b0);
    step("or",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 1'b0);
    step("xor",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1101, 1'b0);
    step("nor",      32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1100, 1'b0);
    step("undef",    32'hDEAD_BEEF, 32'h1234_5678, 4'b1010, 1'b0);
    // Spot-check a few constants from the model independently.
    chk32("const.and", ref_res(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000), 32'h00F0_00F0);
    chk32("const.nor", ref_res(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1100), 32'h000F_000F);
    // Reset beats a flag-producing op, then flags return once released.
    step("rst_win",  32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b1);
    step("rst_rel",  32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
    // Flags clear on a non-arithmetic op.
    step("flag_clr", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0111, 1'b0);

    // Random sweep over all 16 op codes.
    for (int i = 0; i < 400; i++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
      ro = 4'($urandom_range(0, 15));
      step("rand", ra, rb, ro, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
